// File: rtl/cmd_length_counter.sv
// Command-length beat counter with start/busy/done handshake, auto-reload, up/down indexing and abort.
// Outputs are registered except last_beat (comb); one beat consumed per enabled cycle while busy, no backpressure.
module cmd_length_counter #(
    parameter int WORD_LENGTH = 8,
    parameter int COUNT_DOWN  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [WORD_LENGTH-1:0] i_command_length,
    input  logic                   i_auto_reload,
    input  logic                   i_enable,
    input  logic                   i_sync_clear,
    output logic [WORD_LENGTH-1:0] o_count_out,
    output logic [WORD_LENGTH-1:0] o_remaining,
    output logic                   o_busy,
    output logic                   o_last_beat,
    output logic                   o_finish_command,
    output logic                   o_done,
    output logic                   o_len_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WORD_LENGTH-1:0] ONE  = {{(WORD_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_LENGTH-1:0] ZERO = '0;

    logic [1:0]             r_state;
    logic [WORD_LENGTH-1:0] r_len;
    logic [WORD_LENGTH-1:0] r_count;
    logic [WORD_LENGTH-1:0] r_remaining;
    logic                   r_finish;
    logic                   r_done;
    logic                   r_len_error;

    logic                   w_busy;
    logic                   w_rem_is_one;
    logic                   w_len_is_zero;
    logic [WORD_LENGTH-1:0] w_start_index;
    logic [WORD_LENGTH-1:0] w_reload_index;
    logic [WORD_LENGTH-1:0] w_next_index;

    assign w_busy        = (r_state == S_COUNT);
    assign w_rem_is_one  = (r_remaining == ONE);
    assign w_len_is_zero = (i_command_length == ZERO);

    // Down-counting starts at len-1; only evaluated when len is known non-zero, so no underflow is observed.
    assign w_start_index  = (COUNT_DOWN != 0) ? (i_command_length - ONE) : ZERO;
    assign w_reload_index = (COUNT_DOWN != 0) ? (r_len - ONE) : ZERO;
    assign w_next_index   = (COUNT_DOWN != 0) ? (r_count - ONE) : (r_count + ONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_len       <= ZERO;
            r_count     <= ZERO;
            r_remaining <= ZERO;
            r_finish    <= 1'b0;
            r_done      <= 1'b0;
            r_len_error <= 1'b0;
        end else begin
            r_finish    <= 1'b0;
            r_len_error <= 1'b0;
            if (i_sync_clear) begin
                r_state     <= S_IDLE;
                r_count     <= ZERO;
                r_remaining <= ZERO;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_start) begin
                            if (w_len_is_zero) begin
                                r_len_error <= 1'b1;
                            end else begin
                                r_len       <= i_command_length;
                                r_remaining <= i_command_length;
                                r_count     <= w_start_index;
                                r_done      <= 1'b0;
                                r_state     <= S_COUNT;
                            end
                        end
                    end
                    S_COUNT: begin
                        if (i_enable) begin
                            if (w_rem_is_one) begin
                                r_finish <= 1'b1;
                                if (i_auto_reload) begin
                                    r_remaining <= r_len;
                                    r_count     <= w_reload_index;
                                end else begin
                                    r_state     <= S_DONE;
                                    r_done      <= 1'b1;
                                    r_remaining <= ZERO;
                                    r_count     <= ZERO;
                                end
                            end else begin
                                r_remaining <= r_remaining - ONE;
                                r_count     <= w_next_index;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_count_out      = r_count;
    assign o_remaining      = r_remaining;
    assign o_busy           = w_busy;
    assign o_last_beat      = w_busy & w_rem_is_one;
    assign o_finish_command = r_finish;
    assign o_done           = r_done;
    assign o_len_error      = r_len_error;

endmodule

// File: tb/tb_cmd_length_counter.sv
// Bench for cmd_length_counter: table-driven vectors on an up-counting instance, long gapped run on a down-counting one.
module tb_cmd_length_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] rem;
        logic       busy;
        logic       last;
        logic       fin;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       st;
        logic [7:0] len;
        logic       ar;
        logic       en;
        logic       clr;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, st, ar, en, clr;
    logic [7:0] len;

    logic [7:0] u_cnt, u_rem, d_cnt, d_rem;
    logic       u_busy, u_last, u_fin, u_done, u_err;
    logic       d_busy, d_last, d_fin, d_done, d_err;

    cmd_length_counter #(.WORD_LENGTH(8), .COUNT_DOWN(0)) u_up (
        .i_clk(clk), .i_reset(rst), .i_start(st), .i_command_length(len),
        .i_auto_reload(ar), .i_enable(en), .i_sync_clear(clr),
        .o_count_out(u_cnt), .o_remaining(u_rem), .o_busy(u_busy), .o_last_beat(u_last),
        .o_finish_command(u_fin), .o_done(u_done), .o_len_error(u_err)
    );

    cmd_length_counter #(.WORD_LENGTH(8), .COUNT_DOWN(1)) u_dn (
        .i_clk(clk), .i_reset(rst), .i_start(st), .i_command_length(len),
        .i_auto_reload(ar), .i_enable(en), .i_sync_clear(clr),
        .o_count_out(d_cnt), .o_remaining(d_rem), .o_busy(d_busy), .o_last_beat(d_last),
        .o_finish_command(d_fin), .o_done(d_done), .o_len_error(d_err)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  sb_q[$];
    string nm_q[$];
    vec_t  vecs[$];

    function automatic vec_t v(input string nm, input logic r, input logic s, input int l,
                               input logic a, input logic e, input logic c,
                               input int cnt, input int rem, input logic busy, input logic last,
                               input logic fin, input logic done, input logic err);
        vec_t x;
        x.name = nm; x.rst = r; x.st = s; x.len = l[7:0]; x.ar = a; x.en = e; x.clr = c;
        x.exp.cnt = cnt[7:0]; x.exp.rem = rem[7:0];
        x.exp.busy = busy; x.exp.last = last; x.exp.fin = fin; x.exp.done = done; x.exp.err = err;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst = x.rst; st = x.st; len = x.len; ar = x.ar; en = x.en; clr = x.clr;
        sb_q.push_back(x.exp);
        nm_q.push_back(x.name);
    endtask

    task automatic check(input bit use_dn);
        exp_t  e;
        exp_t  a;
        string nm;
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        if (use_dn) a = {d_cnt, d_rem, d_busy, d_last, d_fin, d_done, d_err};
        else        a = {u_cnt, u_rem, u_busy, u_last, u_fin, u_done, u_err};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d rem=%0d busy=%b last=%b fin=%b done=%b err=%b, want cnt=%0d rem=%0d busy=%b last=%b fin=%b done=%b err=%b",
                     nm, a.cnt, a.rem, a.busy, a.last, a.fin, a.done, a.err,
                     e.cnt, e.rem, e.busy, e.last, e.fin, e.done, e.err);
        end
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; len = 8'd0; ar = 1'b0; en = 1'b0; clr = 1'b0;

        //                name       rst st len ar en clr  cnt rem busy last fin done err
        vecs.push_back(v("reset",     1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        // T2: one-shot len=4
        vecs.push_back(v("t2_start",  0, 1,  4, 0, 0, 0,   0, 4, 1, 0, 0, 0, 0));
        vecs.push_back(v("t2_b0",     0, 0,  0, 0, 1, 0,   1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(v("t2_b1",     0, 0,  0, 0, 1, 0,   2, 2, 1, 0, 0, 0, 0));
        vecs.push_back(v("t2_b2",     0, 0,  0, 0, 1, 0,   3, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("t2_final",  0, 0,  0, 0, 1, 0,   0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v("t2_after",  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0));
        // T5a: zero length from DONE
        vecs.push_back(v("t5_len0",   0, 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v("t5_len0_n", 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0));
        // T3: auto-reload len=3, nine beats
        vecs.push_back(v("t3_start",  0, 1,  3, 1, 0, 0,   0, 3, 1, 0, 0, 0, 0));
        for (int k = 0; k < 9; k++) begin
            case (k % 3)
                0: vecs.push_back(v("t3_beat", 0, 0, 0, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0));
                1: vecs.push_back(v("t3_beat", 0, 0, 0, 1, 1, 0, 2, 1, 1, 1, 0, 0, 0));
                default: vecs.push_back(v("t3_wrap", 0, 0, 0, 1, 1, 0, 0, 3, 1, 0, 1, 0, 0));
            endcase
        end
        // T5b: start during COUNT ignored, length 3 kept
        vecs.push_back(v("t5_ign",    0, 1,  6, 0, 0, 0,   0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(v("t5_ign_en", 0, 1,  6, 0, 1, 0,   1, 2, 1, 0, 0, 0, 0));
        vecs.push_back(v("t5_b1",     0, 0,  0, 0, 1, 0,   2, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("t5_hold",   0, 0,  0, 0, 0, 0,   2, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("t5_final",  0, 0,  0, 0, 1, 0,   0, 0, 0, 0, 1, 1, 0));
        // T6: abort on final beat
        vecs.push_back(v("t6_start",  0, 1,  2, 0, 0, 0,   0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(v("t6_b0",     0, 0,  0, 0, 1, 0,   1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("t6_clr",    0, 0,  0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("t6_after",  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("t6_clr_st", 0, 1,  5, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        // T1: reset mid-command, then restart
        vecs.push_back(v("t1_start",  0, 1,  5, 0, 0, 0,   0, 5, 1, 0, 0, 0, 0));
        vecs.push_back(v("t1_b0",     0, 0,  0, 0, 1, 0,   1, 4, 1, 0, 0, 0, 0));
        vecs.push_back(v("t1_b1",     0, 0,  0, 0, 1, 0,   2, 3, 1, 0, 0, 0, 0));
        vecs.push_back(v("t1_reset",  1, 1,  7, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("t1_restart",0, 1,  5, 0, 0, 0,   0, 5, 1, 0, 0, 0, 0));
        vecs.push_back(v("t1_b0b",    0, 0,  0, 0, 1, 0,   1, 4, 1, 0, 0, 0, 0));
        vecs.push_back(v("t1_clr",    0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        // len=1 with auto-reload: every enabled beat is final
        vecs.push_back(v("l1_start",  0, 1,  1, 1, 0, 0,   0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("l1_b0",     0, 0,  0, 1, 1, 0,   0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(v("l1_b1",     0, 0,  0, 1, 1, 0,   0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(v("l1_gap",    0, 0,  0, 1, 0, 0,   0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(v("l1_clr",    0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check(1'b0);
        end

        // T4: down counter, len=255, enable on every other cycle
        drive(v("t4_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check(1'b1);
        drive(v("t4_start", 0, 1, 255, 0, 0, 0, 254, 255, 1, 0, 0, 0, 0));
        check(1'b1);
        for (int k = 0; k < 255; k++) begin
            drive(v("t4_gap", 0, 0, 0, 0, 0, 0, 254 - k, 255 - k, 1, (k == 254), 0, 0, 0));
            check(1'b1);
            if (k < 254)
                drive(v("t4_beat", 0, 0, 0, 0, 1, 0, 253 - k, 254 - k, 1, (k == 253), 0, 0, 0));
            else
                drive(v("t4_final", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
            check(1'b1);
        end
        drive(v("t4_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
